seq_divider: RTL and testbench

//  Multi-cycle 32-bit integer divider for the pipeline CPU's DIV/REM path. Inverse of the adder path:
//  one restoring-division step per clock, each step a trial subtract through a borrow look-ahead chain.

---
 rtl/seq_divider_pkg.sv | 7 +
 rtl/seq_divider_bla.sv | 19 +
 rtl/seq_divider.sv | 91 +++++++++
 tb/tb_seq_divider.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: FSM state encodings shared by the divider files
package seq_divider_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/seq_divider_bla.sv
// bla_block: 4-bit borrow look-ahead for a - b, borrows fully expanded per bit
module bla_block (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bi,
  output logic       b1,
  output logic       b2,
  output logic       b3,
  output logic       bo
);
  logic [3:0] g, p;
  assign g  = ~a & b;
  assign p  = ~a | b;
  assign b1 = g[0] | p[0] & bi;
  assign b2 = g[1] | p[1] & g[0] | p[1] & p[0] & bi;
  assign b3 = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & bi;
  assign bo = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0]
            | p[3] & p[2] & p[1] & p[0] & bi;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one trial subtract per clock
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import seq_divider_pkg::*;
  localparam int CW = $clog2(WIDTH) + 1;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r, q, dvs, diff, shifted, abs_a, abs_b;
  logic             sa, sb, borrow;
  assign busy    = state != IDLE;
  assign done    = state == DONE;
  assign shifted = {r[WIDTH-2:0], q[WIDTH-1]};
  assign abs_a   = (is_signed & dividend[WIDTH-1]) ? ~dividend + WIDTH'(1) : dividend;
  assign abs_b   = (is_signed & divisor[WIDTH-1]) ? ~divisor + WIDTH'(1) : divisor;
  for (genvar g = 0; g < WIDTH / 4; g++) begin : g_bla
    logic bi, b1, b2, b3, bo;
    if (g == 0) begin : g_first
      assign bi = 1'b0;
    end else begin : g_next
      assign bi = g_bla[g-1].bo;
    end
    bla_block u_bla (
      .a (shifted[4*g+3:4*g]),
      .b (dvs[4*g+3:4*g]),
      .bi(bi),
      .b1(b1),
      .b2(b2),
      .b3(b3),
      .bo(bo)
    );
    assign diff[4*g+3:4*g] = shifted[4*g+3:4*g] ^ dvs[4*g+3:4*g] ^ {b3, b2, b1, bi};
  end
  // the partial remainder is WIDTH+1 bits wide; its top bit is r's MSB against a zero divisor bit
  assign borrow = ~r[WIDTH-1] & g_bla[WIDTH/4-1].bo;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dvs         <= '0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else
      case (state)
        IDLE:
          if (start && divisor == '0) begin
            state       <= DONE;
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else if (start) begin
            state <= CALC;
            q     <= abs_a;
            dvs   <= abs_b;
            r     <= '0;
            cnt   <= '0;
            sa    <= is_signed & dividend[WIDTH-1];
            sb    <= is_signed & divisor[WIDTH-1];
          end
        CALC: begin
          r     <= borrow ? shifted : diff;
          q     <= {q[WIDTH-2:0], ~borrow};
          cnt   <= cnt + CW'(1);
          state <= cnt == CW'(WIDTH - 1) ? FIX : CALC;
        end
        FIX: begin
          quotient    <= (sa ^ sb) ? ~q + WIDTH'(1) : q;
          remainder   <= sa ? ~r + WIDTH'(1) : r;
          div_by_zero <= 1'b0;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: random and directed checks of seq_divider against an arithmetic model
module tb_seq_divider;
  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, is_signed = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  int          vectors = 0, errors = 0, lat;
  int          m_left = 0;
  logic        m_done = 1'b0, m_dbz = 1'b0, prev;
  logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic [63:0] res;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic s);
    logic sa, sb;
    logic [31:0] ma, mb, qq, rr;
    if (b == 0) return {32'hFFFF_FFFF, a};
    sa = s & a[31];
    sb = s & b[31];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    qq = ma / mb;
    rr = ma % mb;
    if (sa ^ sb) qq = -qq;
    if (sa) rr = -rr;
    return {qq, rr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: an accepted start yields done 34 edges later (1 for divide-by-zero)
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_dbz = 1'b0;
    end else begin
      prev = m_done;
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_q = p_q; m_r = p_r; m_dbz = 1'b0;
        end
      end else if (!prev && start) begin
        res = ref_div(dividend, divisor, is_signed);
        if (divisor == 0) begin
          m_done = 1'b1; m_q = res[63:32]; m_r = res[31:0]; m_dbz = 1'b1;
        end else begin
          m_left = 33; p_q = res[63:32]; p_r = res[31:0];
        end
      end
    end

  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, m_left > 0 || m_done});
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
    chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dbz});
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int inj, output int l);
    @(negedge clk);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
    l = 1;
    while (!done && l < 60) begin
      @(negedge clk);
      l++;
      start = l == inj;
      if (l == inj) begin dividend = 5; divisor = 5; end
    end
    start = 1'b0;
    if (!done) begin
      vectors++; errors++;
      $display("FAIL timeout: no done within %0d cycles", l);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    chk("reset quotient", quotient, 32'h0);
    chk("reset remainder", remainder, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset done", {31'b0, done}, 32'h0);
    chk("reset dbz", {31'b0, div_by_zero}, 32'h0);
    reset_n = 1'b1;
    run_op(100, 7, 1'b0, 0, lat);
    chk("100/7 latency", lat, 34);
    chk("100/7 quotient", quotient, 14);
    chk("100/7 remainder", remainder, 2);
    chk("100/7 dbz", {31'b0, div_by_zero}, 32'h0);
    run_op(32'hFFFF_FFF9, 2, 1'b1, 0, lat);
    chk("-7/2 quotient", quotient, 32'hFFFF_FFFD);
    chk("-7/2 remainder", remainder, 32'hFFFF_FFFF);
    run_op(32'hFFFF_FFF9, 2, 1'b0, 0, lat);
    chk("u 0xFFFFFFF9/2 quotient", quotient, 32'h7FFF_FFFC);
    chk("u 0xFFFFFFF9/2 remainder", remainder, 32'h1);
    run_op(32'h1234, 0, 1'b0, 0, lat);
    chk("div0 latency", lat, 1);
    chk("div0 quotient", quotient, 32'hFFFF_FFFF);
    chk("div0 remainder", remainder, 32'h1234);
    chk("div0 dbz", {31'b0, div_by_zero}, 32'h1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, lat);
    chk("INT_MIN/-1 quotient", quotient, 32'h8000_0000);
    chk("INT_MIN/-1 remainder", remainder, 32'h0);
    chk("INT_MIN/-1 dbz", {31'b0, div_by_zero}, 32'h0);
    run_op(32'hFFFF_FFFF, 1, 1'b0, 10, lat);
    chk("ignored start quotient", quotient, 32'hFFFF_FFFF);
    chk("ignored start remainder", remainder, 32'h0);
    start = 1'b1; dividend = 5; divisor = 5;
    @(negedge clk);
    start = 1'b0;
    chk("start in DONE ignored", {31'b0, busy}, 32'h0);
    @(negedge clk);
    dividend = 32'hDEAD_BEEF; divisor = 7; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort quotient", quotient, 32'h0);
    chk("abort remainder", remainder, 32'h0);
    chk("abort busy", {31'b0, busy}, 32'h0);
    chk("abort done", {31'b0, done}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(9, 3, 1'b0, 0, lat);
    chk("9/3 quotient", quotient, 3);
    chk("9/3 remainder", remainder, 0);
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0:       b = 0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      run_op(a, b, 1'($urandom), 0, lat);
      chk("random latency", lat, b == 0 ? 1 : 34);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
